hough_circle_acc: RTL and testbench

- Parametrised circle-Hough voting accumulator; successor to the fixed 4-point, radius-20 accumulator.
- Sits after the edge/threshold stage. Consumes a stream of edge pixels with a valid/ready handshake.
- Per pixel, casts votes into a binned accumulator RAM using read-modify-write with saturation. Tracks the best centre and publishes it on frame_end.
- Adds frame-level clear, back-pressure, bounds checks and saturation.

---
 rtl/hough_circle_acc.sv | 214 +++++++++++++++++++++
 tb/tb_hough_circle_acc.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hough_circle_acc.sv
// ----------------------------------------------------------------------------
// hough_circle_acc - circle-Hough vote accumulator with saturating binned RAM
// and best-centre tracking. Macro HOUGH_DIAG8_EN adds four diagonal candidates.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hough_circle_acc #(
  parameter int IMG_W     = 600,
  parameter int IMG_H     = 400,
  parameter int X_OFF     = 20,
  parameter int Y_OFF     = 40,
  parameter int RADIUS    = 20,
  parameter int ACC_W     = 4,
  parameter int BIN_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [9:0]       X,
  input  logic [8:0]       Y,
  input  logic [3:0]       pixel,
  output logic [9:0]       idealX,
  output logic [8:0]       idealY,
  output logic [ACC_W-1:0] peak_votes,
  output logic             result_valid,
  output logic             busy
);

  localparam int c_ROW_BINS  = IMG_W >> BIN_SHIFT;
  localparam int c_ACC_DEPTH = c_ROW_BINS * (IMG_H >> BIN_SHIFT);
  localparam int c_AW        = $clog2(c_ACC_DEPTH);
`ifdef HOUGH_DIAG8_EN
  localparam int c_NDIR = 8;
  localparam int c_DW   = 3;
  localparam logic signed [11:0] c_D12 = 12'((RADIUS * 181) >> 8);
`else
  localparam int c_NDIR = 4;
  localparam int c_DW   = 2;
`endif
  localparam logic [c_DW-1:0]  c_LAST_DIR  = c_DW'(c_NDIR - 1);
  localparam logic [c_AW-1:0]  c_LAST_ADDR = c_AW'(c_ACC_DEPTH - 1);
  localparam logic [ACC_W-1:0] c_SAT       = '1;
  localparam logic signed [11:0] c_R12    = 12'(RADIUS);
  localparam logic signed [11:0] c_W12    = 12'(IMG_W);
  localparam logic signed [11:0] c_H12    = 12'(IMG_H);
  localparam logic signed [11:0] c_XOFF12 = 12'(X_OFF);
  localparam logic signed [11:0] c_YOFF12 = 12'(Y_OFF);

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_ACCEPT = 2'd1,
    S_RD     = 2'd2,
    S_WR     = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic [ACC_W-1:0] r_mem [c_ACC_DEPTH];
  logic [ACC_W-1:0] r_rd_data;
  logic [c_AW-1:0]  r_clr_addr;
  logic signed [11:0] r_lx, r_ly;
  logic [c_DW-1:0]  r_dir;
  logic [ACC_W-1:0] r_best;
  logic [9:0]       r_best_x;
  logic [8:0]       r_best_y;
  logic             r_end_pend;
  logic [9:0]       r_ideal_x;
  logic [8:0]       r_ideal_y;
  logic [ACC_W-1:0] r_peak;
  logic             r_result_valid;

  logic w_beat_ok, w_take, w_publish, w_cand_ok, w_we;
  logic signed [11:0] w_dx, w_dy, w_cx, w_cy;
  logic [c_AW-1:0]  w_addr, w_waddr;
  logic [ACC_W-1:0] w_new, w_wdata;

  assign w_beat_ok = (pixel != 4'd0)
                  && (int'(X) >= X_OFF) && (int'(X) < X_OFF + IMG_W)
                  && (int'(Y) >= Y_OFF) && (int'(Y) < Y_OFF + IMG_H);
  assign w_take    = (r_state == S_ACCEPT) && pix_valid && w_beat_ok;
  // A simultaneous frame_end/frame_start publishes the pre-clear best.
  assign w_publish = (frame_end && frame_start)
                  || ((r_state == S_ACCEPT) && (frame_end || r_end_pend));

  always_comb begin
    w_dx = '0;
    w_dy = '0;
    case (r_dir)
      c_DW'(0): w_dx = -c_R12;
      c_DW'(1): w_dx = c_R12;
      c_DW'(2): w_dy = -c_R12;
      c_DW'(3): w_dy = c_R12;
`ifdef HOUGH_DIAG8_EN
      c_DW'(4): begin w_dx = -c_D12; w_dy = -c_D12; end
      c_DW'(5): begin w_dx = c_D12;  w_dy = -c_D12; end
      c_DW'(6): begin w_dx = -c_D12; w_dy = c_D12;  end
      c_DW'(7): begin w_dx = c_D12;  w_dy = c_D12;  end
`endif
      default: begin w_dx = '0; w_dy = '0; end
    endcase
  end

  assign w_cx      = r_lx + w_dx;
  assign w_cy      = r_ly + w_dy;
  assign w_cand_ok = !w_cx[11] && (w_cx < c_W12) && !w_cy[11] && (w_cy < c_H12);
  assign w_addr    = c_AW'((int'(w_cy) >>> BIN_SHIFT) * c_ROW_BINS + (int'(w_cx) >>> BIN_SHIFT));
  assign w_new     = (r_rd_data == c_SAT) ? r_rd_data : r_rd_data + ACC_W'(1);

  assign w_we    = rst_n && ((r_state == S_CLEAR)
                          || ((r_state == S_WR) && w_cand_ok && !frame_start));
  assign w_waddr = (r_state == S_CLEAR) ? r_clr_addr : w_addr;
  assign w_wdata = (r_state == S_CLEAR) ? '0 : w_new;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    if ((r_state == S_RD) && w_cand_ok) r_rd_data <= r_mem[w_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_CLEAR;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    pix_ready = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_CLEAR: begin
        busy = 1'b1;
        if (r_clr_addr == c_LAST_ADDR) w_next = S_ACCEPT;
      end
      S_ACCEPT: begin
        pix_ready = 1'b1;
        if (w_take) w_next = S_RD;
      end
      S_RD: begin
        busy   = 1'b1;
        w_next = S_WR;
      end
      S_WR: begin
        busy   = 1'b1;
        w_next = (r_dir == c_LAST_DIR) ? S_ACCEPT : S_RD;
      end
      default: w_next = S_CLEAR;
    endcase
    if (frame_start) w_next = S_CLEAR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clr_addr     <= '0;
      r_lx           <= '0;
      r_ly           <= '0;
      r_dir          <= '0;
      r_best         <= '0;
      r_best_x       <= '0;
      r_best_y       <= '0;
      r_end_pend     <= 1'b0;
      r_ideal_x      <= '0;
      r_ideal_y      <= '0;
      r_peak         <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= w_publish;
      if (w_publish) begin
        r_ideal_x <= r_best_x;
        r_ideal_y <= r_best_y;
        r_peak    <= r_best;
      end
      r_end_pend <= w_publish ? 1'b0 : (r_end_pend | frame_end);

      if (frame_start) begin
        r_clr_addr <= '0;
        r_best     <= '0;
        r_best_x   <= '0;
        r_best_y   <= '0;
      end else begin
        case (r_state)
          S_CLEAR: r_clr_addr <= r_clr_addr + c_AW'(1);
          S_ACCEPT: begin
            if (w_take) begin
              r_lx  <= 12'(int'(X) - X_OFF);
              r_ly  <= 12'(int'(Y) - Y_OFF);
              r_dir <= '0;
            end
          end
          S_WR: begin
            // Strict compare keeps the earlier winner on ties.
            if (w_cand_ok && (w_new > r_best)) begin
              r_best   <= w_new;
              r_best_x <= 10'(w_cx + c_XOFF12);
              r_best_y <= 9'(w_cy + c_YOFF12);
            end
            r_dir <= r_dir + c_DW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign idealX       = r_ideal_x;
  assign idealY       = r_ideal_y;
  assign peak_votes   = r_peak;
  assign result_valid = r_result_valid;

endmodule

`default_nettype wire

// File: tb/tb_hough_circle_acc.sv
// Scoreboard bench for hough_circle_acc: directed frames plus randomized edges
// checked against a plain-arithmetic voting model.
`default_nettype none

module tb_hough_circle_acc;

  localparam int IMG_W     = 600;
  localparam int IMG_H     = 400;
  localparam int X_OFF     = 20;
  localparam int Y_OFF     = 40;
  localparam int RADIUS    = 20;
  localparam int ACC_W     = 4;
  localparam int BIN_SHIFT = 2;
  localparam int ROWB      = IMG_W >> BIN_SHIFT;
  localparam int DEPTH     = ROWB * (IMG_H >> BIN_SHIFT);
  localparam int SAT       = (1 << ACC_W) - 1;
  localparam int DG        = (RADIUS * 181) >> 8;
`ifdef HOUGH_DIAG8_EN
  localparam int NCAND = 8;
`else
  localparam int NCAND = 4;
`endif
  localparam int VOTE_CYC = 2 * NCAND;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_start = 1'b0;
  logic             frame_end = 1'b0;
  logic             pix_valid = 1'b0;
  logic [9:0]       X = '0;
  logic [8:0]       Y = '0;
  logic [3:0]       pixel = '0;
  logic             pix_ready;
  logic [9:0]       idealX;
  logic [8:0]       idealY;
  logic [ACC_W-1:0] peak_votes;
  logic             result_valid;
  logic             busy;

  always #5 clk = ~clk;

  hough_circle_acc #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X_OFF(X_OFF), .Y_OFF(Y_OFF),
    .RADIUS(RADIUS), .ACC_W(ACC_W), .BIN_SHIFT(BIN_SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .X(X), .Y(Y), .pixel(pixel),
    .idealX(idealX), .idealY(idealY), .peak_votes(peak_votes),
    .result_valid(result_valid), .busy(busy)
  );

  typedef struct { int x; int y; int v; } res_t;
  res_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  int acc[DEPTH];
  int m_best, m_bx, m_by;

  function automatic void model_clear();
    foreach (acc[i]) acc[i] = 0;
    m_best = 0; m_bx = 0; m_by = 0;
  endfunction

  function automatic void model_edge(int x, int y, int p);
    int lx, ly, cx, cy, b;
    if (p == 0 || x < X_OFF || x >= X_OFF + IMG_W || y < Y_OFF || y >= Y_OFF + IMG_H) return;
    lx = x - X_OFF;
    ly = y - Y_OFF;
    for (int k = 0; k < NCAND; k++) begin
      case (k)
        0: begin cx = lx - RADIUS; cy = ly; end
        1: begin cx = lx + RADIUS; cy = ly; end
        2: begin cx = lx; cy = ly - RADIUS; end
        3: begin cx = lx; cy = ly + RADIUS; end
        4: begin cx = lx - DG; cy = ly - DG; end
        5: begin cx = lx + DG; cy = ly - DG; end
        6: begin cx = lx - DG; cy = ly + DG; end
        default: begin cx = lx + DG; cy = ly + DG; end
      endcase
      if (cx < 0 || cx >= IMG_W || cy < 0 || cy >= IMG_H) continue;
      b = (cy / (1 << BIN_SHIFT)) * ROWB + cx / (1 << BIN_SHIFT);
      if (acc[b] < SAT) acc[b] = acc[b] + 1;
      if (acc[b] > m_best) begin
        m_best = acc[b]; m_bx = cx + X_OFF; m_by = cy + Y_OFF;
      end
    end
  endfunction

  task automatic check(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Monitor: every result_valid beat is matched against the oldest expectation.
  always @(negedge clk) begin
    res_t e;
    if (rst_n && result_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result: got (%0d,%0d,%0d), required no publication",
                 idealX, idealY, peak_votes);
      end else begin
        e = exp_q.pop_front();
        if (idealX !== 10'(e.x) || idealY !== 9'(e.y) || peak_votes !== ACC_W'(e.v)) begin
          n_bad++;
          $display("FAIL result: got (%0d,%0d,%0d), required (%0d,%0d,%0d)",
                   idealX, idealY, peak_votes, e.x, e.y, e.v);
        end
      end
    end
  end

  task automatic count_low(input int limit, output int n);
    n = 0;
    while (pix_ready !== 1'b1 && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_ready();
    int n;
    count_low(20000, n);
    if (pix_ready !== 1'b1) check("ready_timeout", 0, 1);
  endtask

  task automatic send_pix(input int x, input int y, input int p);
    wait_ready();
    pix_valid = 1'b1;
    X = 10'(x); Y = 9'(y); pixel = 4'(p);
    model_edge(x, y, p);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic pulse_end(input int ex, input int ey, input int ev);
    res_t r;
    r.x = ex; r.y = ey; r.v = ev;
    exp_q.push_back(r);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic publish_model();
    pulse_end(m_bx, m_by, m_best);
  endtask

  task automatic do_frame_start();
    frame_start = 1'b1;
    model_clear();
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic random_edges(input int cnt, input int cxa, input int cya, input int mid_end);
    int x, y, p, mode, d;
    for (int i = 0; i < cnt; i++) begin
      mode = int'($urandom_range(0, 9));
      p = int'($urandom_range(1, 15));
      d = int'($urandom_range(0, 3));
      if (mode <= 6) begin
        x = cxa + (d == 0 ? RADIUS : d == 1 ? -RADIUS : 0) + int'($urandom_range(0, 4)) - 2;
        y = cya + (d == 2 ? RADIUS : d == 3 ? -RADIUS : 0) + int'($urandom_range(0, 4)) - 2;
      end else if (mode == 7) begin
        x = int'($urandom_range(0, 1023));
        y = int'($urandom_range(0, 511));
      end else if (mode == 8) begin
        x = cxa; y = cya; p = 0;
      end else begin
        x = (d[0]) ? X_OFF + int'($urandom_range(0, 25)) : X_OFF + IMG_W - 1 - int'($urandom_range(0, 25));
        y = (d[1]) ? Y_OFF + int'($urandom_range(0, 25)) : Y_OFF + IMG_H - 1 - int'($urandom_range(0, 25));
      end
      send_pix(x, y, p);
      if (i == mid_end) publish_model();
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cxa, cya;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_idealX", idealX, 0);
    check("rst_idealY", idealY, 0);
    check("rst_peak_votes", peak_votes, 0);
    rst_n = 1'b1;
    count_low(20000, n);
    check("clear_cycles", n, DEPTH);

    // Frame 0: directed patterns accumulating in one frame.
    send_pix(120, 140, 5);
    count_low(100, n);
    check("vote_cycles", n, VOTE_CYC);
    pulse_end(100, 140, 1);
    send_pix(10, 140, 5);
    check("drop_x_ready", pix_ready, 1);
    send_pix(200, 200, 0);
    check("drop_pix0_ready", pix_ready, 1);
    check("drop_pix0_busy", busy, 0);
    send_pix(220, 200, 3);
    send_pix(180, 200, 3);
    send_pix(200, 220, 3);
    send_pix(200, 180, 3);
    wait_ready();
    pulse_end(200, 200, 4);
    repeat (20) send_pix(220, 200, 7);
    wait_ready();
    pulse_end(200, 200, 15);
    repeat (5) @(negedge clk);
    check("hold_peak", peak_votes, 15);

    // Frame 1: left candidate outside the window, then random edges.
    do_frame_start();
    check("clear_busy", busy, 1);
    send_pix(25, 140, 9);
    count_low(100, n);
    check("vote_cycles_oob", n, VOTE_CYC);
    pulse_end(45, 140, 1);
    cxa = int'($urandom_range(X_OFF + 40, X_OFF + IMG_W - 41));
    cya = int'($urandom_range(Y_OFF + 40, Y_OFF + IMG_H - 41));
    random_edges(40, cxa, cya, 20);
    wait_ready();
    publish_model();

    // Abort a vote on its third cycle.
    send_pix(cxa, cya, 4);
    @(negedge clk);
    @(negedge clk);
    do_frame_start();
    wait_ready();
    pulse_end(0, 0, 0);

    // Frame 2: random edges, closed by simultaneous frame_end + frame_start.
    cxa = int'($urandom_range(X_OFF + 40, X_OFF + IMG_W - 41));
    cya = int'($urandom_range(Y_OFF + 40, Y_OFF + IMG_H - 41));
    random_edges(30, cxa, cya, -1);
    wait_ready();
    exp_q.push_back('{x: m_bx, y: m_by, v: m_best});
    frame_end = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    frame_start = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("clear_after_both", busy, 1);
    check("results_outstanding", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
